// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int UART_WIDTH_DEF   = 8;
  localparam int UART_BUSY_TO_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] sel
);

  logic [IW:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest set bit wins.
  always_comb begin
    vld = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW + 1)'(k);
      if (idx >= (IW + 1)'(N)) idx = idx - (IW + 1)'(N);
      if (req[idx[IW-1:0]]) begin
        vld = 1'b1;
        sel = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NREQ byte producers, with busy-ack timeout.
// Define UART_TX_ARB_LOCK_EN to add the per-requester lock input for contiguous multi-byte messages.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int WIDTH   = UART_WIDTH_DEF,
  parameter int BUSY_TO = UART_BUSY_TO_DEF
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        tx_data,
  output logic                    tx_valid,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] active_id,
  output logic                    to_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TO);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TO - 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] data_q, data_d;
  logic            valid_q, valid_d, err_q, err_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   ptr_inc, ptr_done, pick_sel, grant_sel;
  logic            pick_vld, grant_vld;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .sel (pick_sel)
  );

  assign ptr_inc = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
  assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
  logic lkhold_q, lkhold_d, lkbrk_q, lkbrk_d, grant_lock;

  // A honoured lock re-grants the last owner and leaves the pointer where it was.
  always_comb begin
    grant_lock = !lkbrk_q && req[id_q] && lock[id_q];
    grant_vld  = grant_lock || pick_vld;
    grant_sel  = grant_lock ? id_q : pick_sel;
    ptr_done   = lkhold_q ? ptr_q : ptr_inc;
  end
`else
  always_comb begin
    grant_vld = pick_vld;
    grant_sel = pick_sel;
    ptr_done  = ptr_inc;
  end
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lkhold_d = lkhold_q;
    lkbrk_d  = lkbrk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!tx_busy && grant_vld) begin
          data_d         = req_data[grant_sel*WIDTH +: WIDTH];
          id_d           = grant_sel;
          valid_d        = 1'b1;
          ack_d[grant_sel] = 1'b1;
          state_d        = LAUNCH;
`ifdef UART_TX_ARB_LOCK_EN
          lkhold_d = grant_lock;
          lkbrk_d  = 1'b0;
`endif
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          // The byte is abandoned: no second ack, rotation continues.
          if (cnt_inc == CNT_LAST) begin
            err_d   = 1'b1;
            ptr_d   = ptr_inc;
            state_d = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lkbrk_d = 1'b1;
`endif
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          ptr_d   = ptr_done;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lkhold_q <= 1'b0;
      lkbrk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef UART_TX_ARB_LOCK_EN
      lkhold_q <= lkhold_d;
      lkbrk_q  <= lkbrk_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign tx_data   = data_q;
  assign tx_valid  = valid_q;
  assign active_id = id_q;
  assign to_err    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-timing reference model, directed scenarios and random traffic.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 2;
  localparam int WIDTH   = 8;
  localparam int BUSY_TO = 16;
  localparam int IW      = $clog2(NREQ);
  localparam int OW      = 1 + NREQ + 1 + IW + WIDTH;

  localparam int P_FREE = 0, P_LAUNCH = 1, P_AWAIT = 2, P_SENDING = 3;

  logic                  PCLK = 1'b0;
  logic                  PRESETn;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  tx_busy;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      tx_data;
  logic                  tx_valid;
  logic [IW-1:0]         active_id;
  logic                  to_err;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NREQ-1:0]       lock = '0;
`endif

  uart_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BUSY_TO(BUSY_TO)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req       (req),
    .req_data  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_busy   (tx_busy),
    .active_id (active_id),
    .to_err    (to_err)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model: arbiter availability expressed as cycles since launch.
  int               m_phase, m_launch, m_ptr, m_id;
  logic [WIDTH-1:0] m_data;
  logic             e_valid, e_err;
  logic [NREQ-1:0]  e_ack;

  // Stimulus: next-cycle requester values and a simple transmitter model.
  logic [NREQ-1:0]  nx_req = '0;
  logic [WIDTH-1:0] nx_data [NREQ];
  logic             nx_foreign = 1'b0;
  bit               rnd = 1'b0;
  int               dly = 1, hold = 20, bz_start = 0, bz_end = 0;

  int               lq_cyc[$];
  logic [WIDTH-1:0] lq_data[$];
  logic [NREQ-1:0]  lq_ack[$];
  int               eq_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {tx_valid, ack, to_err, active_id, tx_data};
  endfunction

  function automatic logic [OW-1:0] exp_out();
    return {e_valid, e_ack, e_err, IW'(m_id), m_data};
  endfunction

  task automatic model_step();
    int s;
    e_valid = 1'b0;
    e_ack   = '0;
    e_err   = 1'b0;
    case (m_phase)
      P_FREE: begin
        s = pick(req, m_ptr);
        if (!tx_busy && s >= 0) begin
          e_valid  = 1'b1;
          e_ack[s] = 1'b1;
          m_id     = s;
          m_data   = req_data[s*WIDTH +: WIDTH];
          m_launch = cyc + 1;
          m_phase  = P_LAUNCH;
        end
      end
      P_LAUNCH: m_phase = P_AWAIT;
      P_AWAIT: begin
        if (tx_busy) m_phase = P_SENDING;
        else if (cyc - m_launch == BUSY_TO - 1) begin
          e_err   = 1'b1;
          m_ptr   = (m_id + 1) % NREQ;
          m_phase = P_FREE;
        end
      end
      default: begin
        if (!tx_busy) begin
          m_ptr   = (m_id + 1) % NREQ;
          m_phase = P_FREE;
        end
      end
    endcase
  endtask

  task automatic apply_inputs();
    req = nx_req;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = nx_data[i];
    tx_busy = nx_foreign | (cyc >= bz_start && cyc < bz_end);
  endtask

  task automatic step();
    @(negedge PCLK);
    cyc++;
    chk("outputs", dut_out(), exp_out());
    if (tx_valid) begin
      lq_cyc.push_back(cyc);
      lq_data.push_back(tx_data);
      lq_ack.push_back(ack);
      if (rnd) begin
        dly  = $urandom_range(1, 20);
        hold = $urandom_range(1, 10);
      end
      bz_start = cyc + dly;
      bz_end   = bz_start + hold;
    end
    if (to_err) eq_cyc.push_back(cyc);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        if (rnd) begin
          nx_req[i]  = 1'($urandom);
          nx_data[i] = WIDTH'($urandom);
        end
      end else if (rnd && !nx_req[i] && ($urandom % 4 == 0)) begin
        nx_req[i]  = 1'b1;
        nx_data[i] = WIDTH'($urandom);
      end
    end
    if (rnd) nx_foreign = nx_foreign ? ($urandom % 4 != 0) : ($urandom % 64 == 0);
    apply_inputs();
    model_step();
  endtask

  task automatic do_reset();
    #7;
    PRESETn = 1'b0;
    #1;
    chk("reset_async", dut_out(), '0);
    m_phase = P_FREE; m_ptr = 0; m_id = 0; m_data = '0;
    e_valid = 1'b0; e_ack = '0; e_err = 1'b0;
    bz_start = 0; bz_end = 0; nx_foreign = 1'b0;
    lq_cyc.delete(); lq_data.delete(); lq_ack.delete(); eq_cyc.delete();
    @(negedge PCLK);
    cyc++;
    chk("reset_hold", dut_out(), '0);
    PRESETn = 1'b1;
    apply_inputs();
    model_step();
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int k = 0;
    while (lq_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({nm, "_launch_count"}, 32'(lq_cyc.size() >= n), 32'd1);
  endtask

  initial begin
    PRESETn  = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    for (int i = 0; i < NREQ; i++) nx_data[i] = '0;
    do_reset();

    // Single request; second launch 23 cycles later (busy 20 cycles + idle/launch/handshake).
    dly = 1; hold = 20;
    nx_req = 2'b01; nx_data[0] = 8'hA5; nx_data[1] = 8'h5A;
    run_until(2, 80, "single");
    if (lq_cyc.size() >= 2) begin
      chk("single_data", lq_data[0], 8'hA5);
      chk("single_ack", lq_ack[0], 2'b01);
      chk("single_gap", lq_cyc[1] - lq_cyc[0], 23);
    end
    chk("single_no_err", eq_cyc.size(), 0);

    // Contention: strict alternation from pointer 0.
    nx_req = 2'b11; nx_data[0] = 8'h11; nx_data[1] = 8'h22; hold = 3;
    do_reset();
    run_until(4, 100, "contend");
    if (lq_cyc.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("contend_data", lq_data[i], (i % 2 == 0) ? 8'h11 : 8'h22);
        chk("contend_ack", lq_ack[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end

    // Timeout: busy never rises.
    nx_req = 2'b11; nx_data[0] = 8'h33; nx_data[1] = 8'h44; dly = 1000;
    do_reset();
    run_until(2, 80, "timeout");
    chk("timeout_err_count", eq_cyc.size(), 1);
    if (lq_cyc.size() >= 2 && eq_cyc.size() >= 1) begin
      chk("timeout_err_delay", eq_cyc[0] - lq_cyc[0], 16);
      chk("timeout_next_ack", lq_ack[1], 2'b10);
      chk("timeout_next_gap", lq_cyc[1] - lq_cyc[0], 17);
    end

    // Foreign busy in IDLE holds off the grant.
    nx_req = '0; dly = 1; hold = 4;
    do_reset();
    nx_foreign = 1'b1; nx_req = 2'b01; nx_data[0] = 8'h77;
    repeat (6) step();
    chk("foreign_hold", lq_cyc.size(), 0);
    nx_foreign = 1'b0;
    step();
    begin
      int rel;
      rel = cyc;
      run_until(1, 10, "foreign");
      if (lq_cyc.size() >= 1) chk("foreign_gap", lq_cyc[0] - rel, 1);
    end

    // Reset during WAIT_DONE, then requester 1 is served first.
    nx_req = 2'b01; nx_data[0] = 8'h99; hold = 20;
    do_reset();
    run_until(1, 10, "midframe_pre");
    repeat (5) step();
    nx_req = 2'b10; nx_data[1] = 8'hC3;
    do_reset();
    run_until(1, 10, "midframe");
    if (lq_cyc.size() >= 1) begin
      chk("midframe_ack", lq_ack[0], 2'b10);
      chk("midframe_data", lq_data[0], 8'hC3);
    end

    // Random traffic against the model.
    nx_req = '0;
    do_reset();
    rnd = 1'b1;
    repeat (4000) step();
    rnd = 1'b0;
    chk("random_activity", 32'(lq_cyc.size() > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
